ifft_frame_ctrl: RTL and testbench

//  Consumes the IFFT start trigger and IFFT soft-reset control bit from the front-panel slicer.

---
 rtl/ifft_frame_ctrl_if.sv | 28 ++
 rtl/ifft_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_ifft_frame_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifft_frame_ctrl_if.sv
// AXI-Stream bundle from the frame controller to the IFFT core: config channel and bin channel.
// Latency: none, wires only.
// Backpressure: the slave returns tready on each channel; the master holds tdata/tvalid/tlast until accepted.
interface ifft_frame_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic [15:0]       m_cfg_tdata;
  logic              m_cfg_tvalid;
  logic              m_cfg_tready;
  logic [DATA_W-1:0] m_dat_tdata;
  logic              m_dat_tvalid;
  logic              m_dat_tready;
  logic              m_dat_tlast;

  modport master (
    output m_cfg_tdata, m_cfg_tvalid,
    input  m_cfg_tready,
    output m_dat_tdata, m_dat_tvalid, m_dat_tlast,
    input  m_dat_tready
  );

  modport slave (
    input  m_cfg_tdata, m_cfg_tvalid,
    output m_cfg_tready,
    input  m_dat_tdata, m_dat_tvalid, m_dat_tlast,
    output m_dat_tready
  );
endinterface

// File: rtl/ifft_frame_ctrl.sv
// IFFT frame controller: holds one frame of bins, sends one config word per start, then streams the frame.
// Latency: start to first bin valid is 3 cycles with both treadys high; bins then flow at 1 per cycle.
// Backpressure: cfg and bin channels hold their payload while tvalid & !tready; pointer advances only on handshake.
// Optional build macro IFFT_FRAME_CTRL_LOOP_EN adds the `loop` input for continuous back-to-back frames.
module ifft_frame_ctrl #(
  parameter int          NFFT_LOG2 = 10,
  parameter int          DATA_W    = 32,
  parameter logic [11:0] SCALE_SCH = 12'hAAA
) (
  input  logic                 ifft_clk,
  input  logic                 ifft_rst_n,
  input  logic                 soft_reset,
  input  logic                 start,
`ifdef IFFT_FRAME_CTRL_LOOP_EN
  input  logic                 loop,
`endif
  input  logic                 coef_we,
  input  logic [NFFT_LOG2-1:0] coef_addr,
  input  logic [DATA_W-1:0]    coef_data,
  ifft_frame_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           start_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_PREFETCH,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

  state_t               state_q, state_d;
  logic [NFFT_LOG2-1:0] ptr_q, ptr_d;
  logic [7:0]           drop_q, drop_d;
  logic [DATA_W-1:0]    rd_dat_q;
  logic                 rd_en;
  logic                 loop_sel;

  // Bin RAM is deliberately outside any reset so a loaded frame survives aborts.
  logic [DATA_W-1:0]    ram_q [2**NFFT_LOG2];

`ifdef IFFT_FRAME_CTRL_LOOP_EN
  assign loop_sel = loop;
`else
  assign loop_sel = 1'b0;
`endif

  // Config word: forward/inverse bit is 0 (inverse transform), scaling schedule above it.
  assign bus.m_cfg_tdata    = {3'b000, SCALE_SCH, 1'b0};
  assign bus.m_dat_tdata    = rd_dat_q;
  assign start_drop_cnt     = drop_q;

  // Next-state, pointer, drop counter and channel strobes; soft_reset overrides everything last.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    drop_d           = drop_q;
    rd_en            = 1'b0;
    bus.m_cfg_tvalid = 1'b0;
    bus.m_dat_tvalid = 1'b0;
    bus.m_dat_tlast  = 1'b0;
    busy             = (state_q != S_IDLE);
    done             = 1'b0;

    // A start seen in any non-idle state (DONE included) is counted, never queued.
    if (start && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CFG;
      end
      S_CFG: begin
        bus.m_cfg_tvalid = 1'b1;
        if (bus.m_cfg_tready) state_d = S_PREFETCH;
      end
      S_PREFETCH: begin
        // ptr_q is 0 here, so this loads bin 0 into the output register.
        rd_en   = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        bus.m_dat_tvalid = 1'b1;
        bus.m_dat_tlast  = (ptr_q == LAST_BIN);
        if (bus.m_dat_tready) begin
          // Fetch the following bin on the handshake edge; the pointer wraps to 0 after the last.
          ptr_d = ptr_q + 1'b1;
          rd_en = 1'b1;
          if (ptr_q == LAST_BIN) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = loop_sel ? S_PREFETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (soft_reset) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      drop_d  = '0;
      rd_en   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge ifft_clk or negedge ifft_rst_n) begin
    if (!ifft_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read pointer, drop counter and the registered RAM read port (held while stalled).
  always_ff @(posedge ifft_clk or negedge ifft_rst_n) begin
    if (!ifft_rst_n) begin
      ptr_q    <= '0;
      drop_q   <= '0;
      rd_dat_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
      if (rd_en) rd_dat_q <= ram_q[ptr_d];
    end
  end

  // Bin RAM write port; a same-cycle write to the address being read returns the old word.
  always_ff @(posedge ifft_clk) begin
    if (coef_we) ram_q[coef_addr] <= coef_data;
  end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
`timescale 1ns/1ps
module tb_ifft_frame_ctrl;
  localparam int NL2 = 3;
  localparam int NB  = 1 << NL2;
  localparam int DW  = 32;

  logic           ifft_clk   = 1'b0;
  logic           ifft_rst_n = 1'b0;
  logic           soft_reset = 1'b0;
  logic           start      = 1'b0;
  logic           coef_we    = 1'b0;
  logic [NL2-1:0] coef_addr  = '0;
  logic [DW-1:0]  coef_data  = '0;
  logic           busy, done;
  logic [7:0]     start_drop_cnt;
`ifdef IFFT_FRAME_CTRL_LOOP_EN
  logic           loop = 1'b0;
  int             loop_off_at = -1;
`endif

  ifft_frame_ctrl_if #(.DATA_W(DW)) bus ();

  ifft_frame_ctrl #(.NFFT_LOG2(NL2), .DATA_W(DW), .SCALE_SCH(12'hAAA)) dut (
    .ifft_clk       (ifft_clk),
    .ifft_rst_n     (ifft_rst_n),
    .soft_reset     (soft_reset),
    .start          (start),
`ifdef IFFT_FRAME_CTRL_LOOP_EN
    .loop           (loop),
`endif
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .start_drop_cnt (start_drop_cnt)
  );

  always #5 ifft_clk = ~ifft_clk;

  int cyc = 0;
  always @(posedge ifft_clk) cyc <= cyc + 1;

  // Reference state: bin RAM contents and the expected drop counter.
  logic [DW-1:0] mdl [NB];
  int            exp_drop = 0;
  int            n_tests = 0, n_fail = 0;

  // Observations gathered by the stream collector.
  logic [DW-1:0] got_dat [$];
  bit            got_last [$];
  int            got_cyc [$];
  int            done_cyc [$];
  logic [15:0]   got_cfg;
  int            cfg_hs_n, cfg_first_cyc, dat_first_cyc, idle_cyc, stall_bad, start_cyc;
  bit            timed_out, aborted;

  task automatic tick();
    @(posedge ifft_clk);
    #1;
  endtask

  task automatic write_bins(input bit rnd);
    for (int i = 0; i < NB; i++) begin
      mdl[i]    = rnd ? DW'($urandom) : (32'h0001_0000 * i + i);
      coef_we   = 1'b1;
      coef_addr = NL2'(i);
      coef_data = mdl[i];
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  // Acts as the IFFT core sink: drives treadys, records handshakes, optionally injects events.
  task automatic collect(input int mode, input int drop_at, input bit drop_done,
                         input int abort_at, input int budget);
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    bit            prev_stall = 1'b0, drop_fired = 1'b0, fin = 1'b0;
    int            k = 0;
    got_dat.delete(); got_last.delete(); got_cyc.delete(); done_cyc.delete();
    cfg_hs_n = 0; cfg_first_cyc = -1; dat_first_cyc = -1; idle_cyc = -1;
    stall_bad = 0; timed_out = 1'b0; aborted = 1'b0; got_cfg = '0;
    for (int n = 0; n < budget && !fin; n++) begin
      start = 1'b0;
      bus.m_cfg_tready = 1'b1;
      case (mode)
        0:       bus.m_dat_tready = 1'b1;
        1:       bus.m_dat_tready = (k % 3 == 0);
        default: bus.m_dat_tready = 1'($urandom_range(0, 1));
      endcase
      if (bus.m_cfg_tvalid) begin
        if (cfg_first_cyc < 0) cfg_first_cyc = cyc;
        got_cfg = bus.m_cfg_tdata;
        cfg_hs_n++;
      end
      if (bus.m_dat_tvalid) begin
        if (dat_first_cyc < 0) dat_first_cyc = cyc;
        if (prev_stall && (bus.m_dat_tdata !== prev_d || bus.m_dat_tlast !== prev_l)) stall_bad++;
        if (got_dat.size() == drop_at && !drop_fired) begin
          start = 1'b1;
          drop_fired = 1'b1;
        end
        if (got_dat.size() == abort_at) begin
          soft_reset = 1'b1;
          start = 1'b1;
          bus.m_dat_tready = 1'b0;
          aborted = 1'b1;
        end
        k++;
        prev_stall = !bus.m_dat_tready;
        prev_d = bus.m_dat_tdata;
        prev_l = bus.m_dat_tlast;
        if (bus.m_dat_tready) begin
          got_dat.push_back(bus.m_dat_tdata);
          got_last.push_back(bus.m_dat_tlast);
          got_cyc.push_back(cyc);
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (drop_done && done_cyc.size() == 1) start = 1'b1;
      end
`ifdef IFFT_FRAME_CTRL_LOOP_EN
      if (got_dat.size() == loop_off_at) loop = 1'b0;
`endif
      if (n > 0 && !busy) begin
        idle_cyc = cyc;
        fin = 1'b1;
      end
      if (aborted) fin = 1'b1;
      if (!fin || aborted) tick();
    end
    if (!fin) timed_out = 1'b1;
    soft_reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    ifft_rst_n = 1'b0;
    start = 1'b1;
    bus.m_cfg_tready = 1'b1;
    bus.m_dat_tready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({bus.m_cfg_tvalid, bus.m_dat_tvalid, bus.m_dat_tlast, busy, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.m_cfg_tvalid, bus.m_dat_tvalid, bus.m_dat_tlast, busy, done});
    end
    n_tests++;
    if (start_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", start_drop_cnt);
    end
    start = 1'b0;
    ifft_rst_n = 1'b1;
    exp_drop = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.m_cfg_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_release_idle: cfg_tvalid=%b busy=%b want 0 0", bus.m_cfg_tvalid, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    write_bins(1'b0);
    pulse_start();
    collect(0, -1, 1'b0, -1, 200);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL single_timeout: got 1 want 0"); end
    n_tests++;
    if (cfg_first_cyc !== start_cyc + 1) begin
      n_fail++; $display("FAIL single_cfg_latency: got %0d want %0d", cfg_first_cyc - start_cyc, 1);
    end
    n_tests++;
    if (got_cfg !== 16'h1554 || cfg_hs_n !== 1) begin
      n_fail++; $display("FAIL single_cfg_word: got %h x%0d want 1554 x1", got_cfg, cfg_hs_n);
    end
    n_tests++;
    if (dat_first_cyc !== start_cyc + 3) begin
      n_fail++; $display("FAIL single_dat_latency: got %0d want 3", dat_first_cyc - start_cyc);
    end
    n_tests++;
    if (got_dat.size() !== NB) begin
      n_fail++; $display("FAIL single_count: got %0d want %0d", got_dat.size(), NB);
    end
    for (int i = 0; i < got_dat.size() && i < NB; i++) begin
      n_tests++;
      if (got_dat[i] !== mdl[i] || got_last[i] !== (i == NB - 1) || got_cyc[i] !== got_cyc[0] + i) begin
        n_fail++;
        $display("FAIL single_bin%0d: got %h last=%b dt=%0d want %h last=%b dt=%0d",
                 i, got_dat[i], got_last[i], got_cyc[i] - got_cyc[0], mdl[i], (i == NB - 1), i);
      end
    end
    n_tests++;
    if (done_cyc.size() !== 1 || got_cyc.size() == 0) begin
      n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cyc.size());
    end else if (done_cyc[0] !== got_cyc[got_cyc.size()-1] + 1 || idle_cyc !== done_cyc[0] + 1) begin
      n_fail++;
      $display("FAIL single_done_timing: done_dt=%0d idle_dt=%0d want 1 1",
               done_cyc[0] - got_cyc[got_cyc.size()-1], idle_cyc - done_cyc[0]);
    end
  endtask

  // mode 1 is the 1,0,0 ready pattern; mode 2 is random ready.
  task automatic test_backpressure(input int mode, input int reps);
    for (int r = 0; r < reps; r++) begin
      write_bins(1'b1);
      pulse_start();
      collect(mode, -1, 1'b0, -1, 300);
      n_tests++;
      if (timed_out || stall_bad !== 0) begin
        n_fail++; $display("FAIL bp%0d_stall: timeout=%b unstable=%0d want 0 0", mode, timed_out, stall_bad);
      end
      n_tests++;
      if (got_dat.size() !== NB || done_cyc.size() !== 1) begin
        n_fail++; $display("FAIL bp%0d_count: got %0d bins %0d done want %0d 1", mode, got_dat.size(), done_cyc.size(), NB);
      end
      for (int i = 0; i < got_dat.size() && i < NB; i++) begin
        n_tests++;
        if (got_dat[i] !== mdl[i] || got_last[i] !== (i == NB - 1)) begin
          n_fail++; $display("FAIL bp%0d_bin%0d: got %h/%b want %h/%b", mode, i, got_dat[i], got_last[i], mdl[i], (i == NB - 1));
        end
      end
    end
  endtask

  task automatic test_drop_while_busy();
    write_bins(1'b1);
    pulse_start();
    collect(0, 3, 1'b1, -1, 200);
    exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
    n_tests++;
    if (timed_out || got_dat.size() !== NB || done_cyc.size() !== 1 || cfg_hs_n !== 1) begin
      n_fail++; $display("FAIL drop_frame: bins=%0d done=%0d cfg=%0d want %0d 1 1", got_dat.size(), done_cyc.size(), cfg_hs_n, NB);
    end
    for (int i = 0; i < got_dat.size() && i < NB; i++) begin
      n_tests++;
      if (got_dat[i] !== mdl[i]) begin
        n_fail++; $display("FAIL drop_bin%0d: got %h want %h", i, got_dat[i], mdl[i]);
      end
    end
    tick();
    n_tests++;
    if (start_drop_cnt !== 8'(exp_drop) || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_cnt: got %0d busy=%b want %0d busy=0", start_drop_cnt, busy, exp_drop);
    end
  endtask

  task automatic test_soft_reset();
    write_bins(1'b1);
    pulse_start();
    collect(0, -1, 1'b0, 4, 200);
    exp_drop = 0;
    n_tests++;
    if (!aborted || got_dat.size() !== 4) begin
      n_fail++; $display("FAIL srst_point: aborted=%b bins=%0d want 1 4", aborted, got_dat.size());
    end
    for (int i = 0; i < got_last.size(); i++) begin
      n_tests++;
      if (got_last[i] !== 1'b0) begin n_fail++; $display("FAIL srst_tlast%0d: got 1 want 0", i); end
    end
    n_tests++;
    if (bus.m_dat_tvalid !== 1'b0 || bus.m_dat_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL srst_outputs: tvalid=%b tlast=%b busy=%b done=%b want 0 0 0 0",
                         bus.m_dat_tvalid, bus.m_dat_tlast, busy, done);
    end
    n_tests++;
    if (start_drop_cnt !== 8'(exp_drop)) begin
      n_fail++; $display("FAIL srst_drop_cnt: got %0d want %0d", start_drop_cnt, exp_drop);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || bus.m_cfg_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL srst_start_ignored: busy=%b cfg_tvalid=%b want 0 0", busy, bus.m_cfg_tvalid);
    end
    pulse_start();
    collect(0, -1, 1'b0, -1, 200);
    n_tests++;
    if (timed_out || got_dat.size() !== NB) begin
      n_fail++; $display("FAIL srst_restart_count: got %0d want %0d", got_dat.size(), NB);
    end
    for (int i = 0; i < got_dat.size() && i < NB; i++) begin
      n_tests++;
      if (got_dat[i] !== mdl[i]) begin
        n_fail++; $display("FAIL srst_restart_bin%0d: got %h want %h", i, got_dat[i], mdl[i]);
      end
    end
  endtask

  task automatic test_drop_saturation();
    write_bins(1'b1);
    bus.m_cfg_tready = 1'b0;
    pulse_start();
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      if (i == 99) begin
        n_tests++;
        if (start_drop_cnt !== 8'(exp_drop)) begin
          n_fail++; $display("FAIL sat_mid: got %0d want %0d", start_drop_cnt, exp_drop);
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if (start_drop_cnt !== 8'(exp_drop) || busy !== 1'b1) begin
      n_fail++; $display("FAIL sat_cnt: got %0d busy=%b want %0d busy=1", start_drop_cnt, busy, exp_drop);
    end
    n_tests++;
    if (bus.m_cfg_tvalid !== 1'b1 || bus.m_cfg_tdata !== 16'h1554) begin
      n_fail++; $display("FAIL sat_cfg_hold: got %b/%h want 1/1554", bus.m_cfg_tvalid, bus.m_cfg_tdata);
    end
    collect(0, -1, 1'b0, -1, 200);
    n_tests++;
    if (timed_out || cfg_hs_n !== 1 || got_dat.size() !== NB) begin
      n_fail++; $display("FAIL sat_frame: cfg=%0d bins=%0d want 1 %0d", cfg_hs_n, got_dat.size(), NB);
    end
    for (int i = 0; i < got_dat.size() && i < NB; i++) begin
      n_tests++;
      if (got_dat[i] !== mdl[i]) begin
        n_fail++; $display("FAIL sat_bin%0d: got %h want %h", i, got_dat[i], mdl[i]);
      end
    end
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    exp_drop = 0;
    n_tests++;
    if (start_drop_cnt !== 8'(exp_drop)) begin
      n_fail++; $display("FAIL sat_clear: got %0d want %0d", start_drop_cnt, exp_drop);
    end
  endtask

`ifdef IFFT_FRAME_CTRL_LOOP_EN
  task automatic test_loop();
    write_bins(1'b1);
    loop = 1'b1;
    loop_off_at = NB + 1;
    pulse_start();
    collect(0, -1, 1'b0, -1, 300);
    loop = 1'b0;
    loop_off_at = -1;
    n_tests++;
    if (timed_out || got_dat.size() !== 2 * NB || cfg_hs_n !== 1 || done_cyc.size() !== 2) begin
      n_fail++; $display("FAIL loop_counts: bins=%0d cfg=%0d done=%0d want %0d 1 2",
                         got_dat.size(), cfg_hs_n, done_cyc.size(), 2 * NB);
    end
    for (int i = 0; i < got_dat.size() && i < 2 * NB; i++) begin
      n_tests++;
      if (got_dat[i] !== mdl[i % NB] || got_last[i] !== (i % NB == NB - 1)) begin
        n_fail++; $display("FAIL loop_bin%0d: got %h/%b want %h/%b", i, got_dat[i], got_last[i], mdl[i % NB], (i % NB == NB - 1));
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_idle: busy=%b want 0", busy); end
  endtask
`endif

  initial begin
    bus.m_cfg_tready = 1'b0;
    bus.m_dat_tready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure(1, 1);
    test_backpressure(2, 3);
    test_drop_while_busy();
    test_soft_reset();
    test_drop_saturation();
`ifdef IFFT_FRAME_CTRL_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
